// File: rtl/sift_pkg.sv
// Shared SIFT pipeline types and constants used by the descriptor reader.
// Holds the descriptor word geometry, reader FSM state type and the terminator word.
package sift_pkg;

  localparam int DESC_WORD_WIDTH = 24;
  localparam int DESC_WORDS      = 4;

  // An all-zero word; two of them back to back in slots 0 and 1 end the list.
  localparam logic [DESC_WORD_WIDTH-1:0] TERM_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_OUTPUT = 2'd2,
    ST_DONE   = 2'd3
  } desc_reader_state;

endpackage

// File: rtl/bram_word_fetch.sv
// Address register and read-latency wait counter for the descriptor BRAM.
// word_valid pulses for one cycle when the word at the current address is on rd_data.
module bram_word_fetch #(
  parameter int DEPTH        = 4000,
  parameter int READ_LATENCY = 2,
  parameter int WORD_WIDTH   = 24
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     clear,
  input  logic                     fetch_en,
  input  logic [WORD_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     at_end,
  output logic                     word_valid,
  output logic [WORD_WIDTH-1:0]    word_data
);

  // One spare bit so the address can sit at DEPTH without wrapping.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  logic [CW-1:0] addr_cnt;
  logic [LW-1:0] wait_cnt;

  assign word_valid = fetch_en && (wait_cnt == LW'(READ_LATENCY));
  assign word_data  = rd_data;
  assign rd_addr    = addr_cnt[$clog2(DEPTH)-1:0];
  assign at_end     = (addr_cnt == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      addr_cnt <= '0;
      wait_cnt <= '0;
    end else if (clear) begin
      addr_cnt <= '0;
      wait_cnt <= '0;
    end else if (word_valid) begin
      addr_cnt <= addr_cnt + 1'b1;
      wait_cnt <= '0;
    end else if (fetch_en) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/descriptor_reader.sv
// Streams packed keypoint descriptors out of the descriptor BRAM until a terminator or table end.
// Optional feature macro: DESC_READER_CHECKSUM_EN adds an XOR checksum of emitted words.
module descriptor_reader
  import sift_pkg::*;
#(
  parameter int NUMBER_DESCRIPTORS = 4000,
  parameter int PATCH_SIZE         = 4,
  parameter int WORDS_PER_DESC     = DESC_WORDS,
  parameter int READ_LATENCY       = 2,
  localparam int WORD_WIDTH        = ($clog2(PATCH_SIZE/2*PATCH_SIZE/2)+1)*8,
  localparam int ADDR_WIDTH        = $clog2(NUMBER_DESCRIPTORS)
) (
  input  logic                                 clk,
  input  logic                                 rst_in,
  input  logic                                 start,
  output logic [ADDR_WIDTH-1:0]                desc_read_addr,
  input  logic [WORD_WIDTH-1:0]                desc_read_data,
  output logic [WORDS_PER_DESC*WORD_WIDTH-1:0] desc_data,
  output logic                                 desc_valid,
  input  logic                                 desc_ready,
  output logic [9:0]                           desc_index,
  output logic                                 busy,
  output logic                                 done,
`ifdef DESC_READER_CHECKSUM_EN
  output logic [WORD_WIDTH-1:0]                checksum,
`endif
  output desc_reader_state                     state_dbg
);

  localparam int IW = (WORDS_PER_DESC > 1) ? $clog2(WORDS_PER_DESC) : 1;

  desc_reader_state    state;
  logic [IW-1:0]       word_idx;
  logic [WORD_WIDTH-1:0] slot [WORDS_PER_DESC];

  logic                  fetch_clear;
  logic                  fetch_en;
  logic                  word_valid;
  logic                  at_end;
  logic [WORD_WIDTH-1:0] word_data;

  assign fetch_clear = (state == ST_IDLE) && start;
  assign fetch_en    = (state == ST_FETCH);
  assign state_dbg   = state;

  bram_word_fetch #(
    .DEPTH        (NUMBER_DESCRIPTORS),
    .READ_LATENCY (READ_LATENCY),
    .WORD_WIDTH   (WORD_WIDTH)
  ) u_fetch (
    .clk        (clk),
    .rst_in     (rst_in),
    .clear      (fetch_clear),
    .fetch_en   (fetch_en),
    .rd_data    (desc_read_data),
    .rd_addr    (desc_read_addr),
    .at_end     (at_end),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Handshake: a descriptor transfers on a clock edge where desc_valid && desc_ready;
  // desc_valid/desc_data are registered and held unchanged until that edge.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state      <= ST_IDLE;
      word_idx   <= '0;
      desc_data  <= '0;
      desc_valid <= 1'b0;
      desc_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < WORDS_PER_DESC; k++) slot[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= ST_FETCH;
            busy       <= 1'b1;
            word_idx   <= '0;
            desc_index <= '0;
          end
        end
        ST_FETCH: begin
          if (word_valid) begin
            slot[word_idx] <= word_data;
            word_idx       <= word_idx + 1'b1;
            if (word_idx == IW'(1) && slot[0] == TERM_WORD && word_data == TERM_WORD) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (word_idx == IW'(WORDS_PER_DESC - 1)) begin
              state      <= ST_OUTPUT;
              desc_valid <= 1'b1;
              for (int k = 0; k < WORDS_PER_DESC - 1; k++)
                desc_data[k*WORD_WIDTH +: WORD_WIDTH] <= slot[k];
              desc_data[(WORDS_PER_DESC-1)*WORD_WIDTH +: WORD_WIDTH] <= word_data;
            end
          end
        end
        ST_OUTPUT: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            desc_index <= desc_index + 10'd1;
            word_idx   <= '0;
            // Table fully consumed without a terminator: stop before reading past the end.
            if (at_end) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DESC_READER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] desc_xor;

  always_comb begin
    desc_xor = '0;
    for (int k = 0; k < WORDS_PER_DESC; k++)
      desc_xor = desc_xor ^ desc_data[k*WORD_WIDTH +: WORD_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      checksum <= '0;
    end else if (fetch_clear) begin
      checksum <= '0;
    end else if (state == ST_OUTPUT && desc_valid && desc_ready) begin
      checksum <= checksum ^ desc_xor;
    end
  end
`endif

endmodule
